// File: rtl/dec_pkg.sv
// dec_pkg: shared definitions for the AES-128 decrypt datapath.
//   NR_AES128  : number of cipher rounds (store depth is NR_AES128+1)
//   blk_t      : 128-bit AES block as [row][col][bit]; byte k lives at [k%4][k/4]
//   ks_state_e : key-schedule FSM states
//   sbox_fwd() : forward AES S-box (the inverse S-box is kept elsewhere)
//   rcon_of()  : round constant for expansion steps 1..10
package dec_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [3:0][3:0][7:0] blk_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    // Entry 0 sits in the most significant byte, so SBOX_FWD[x] is S(x).
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_FWD[x];
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dec_keyschedule_key_round_step.sv
// key_round_step: one combinational AES-128 key expansion step.
//   i_prev  : previous round key (columns w0..w3)
//   i_rcon  : round constant for this step
//   o_next  : next round key
module key_round_step
    import dec_pkg::*;
(
    input  blk_t       i_prev,
    input  logic [7:0] i_rcon,
    output blk_t       o_next
);

    logic [3:0][7:0] w_t;

    // RotWord moves row r+1 of w3 into row r before substitution;
    // the round constant only touches row 0.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_t[r] = sbox_fwd(i_prev[(r + 1) % 4][3]);
        end
        w_t[0] = w_t[0] ^ i_rcon;
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            o_next[r][0] = i_prev[r][0] ^ w_t[r];
            for (int c = 1; c < 4; c++) begin
                o_next[r][c] = i_prev[r][c] ^ o_next[r][c-1];
            end
        end
    end

endmodule

// File: rtl/dec_keyschedule.sv
// dec_keyschedule: AES-128 key expansion for the decrypt datapath.
// Expands one round key per clock into an (NR+1)-entry store, then serves
// keys in decrypt order (decrypt round d gets encrypt round key NR-d).
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   key_in   : cipher key, byte k at [k%4][k/4]
//   load     : 1-cycle pulse, sample key_in and (re)start expansion
//   rd_round : decrypt round index 0..NR
//   busy     : expansion in progress
//   ready    : store valid
//   rk_out   : stored key[NR - rd_round], 0 when not ready or out of range
module dec_keyschedule
    import dec_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic       clk,
    input  logic       rst,
    input  blk_t       key_in,
    input  logic       load,
    input  logic [3:0] rd_round,
    output logic       busy,
    output logic       ready,
    output blk_t       rk_out
);

    localparam logic [3:0] NR4 = 4'(NR);

    ks_state_e  r_state;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_ready;
    blk_t       r_store [0:NR];

    blk_t       w_prev;
    blk_t       w_next;

    assign w_prev = r_store[r_cnt - 4'd1];

    key_round_step u_step (
        .i_prev (w_prev),
        .i_rcon (rcon_of(r_cnt)),
        .o_next (w_next)
    );

    // load wins in every state, so a load mid-expansion simply restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                r_store[i] <= '0;
            end
        end else if (load) begin
            r_state    <= EXPAND;
            r_cnt      <= 4'd1;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
            r_store[0] <= key_in;
        end else begin
            case (r_state)
                EXPAND: begin
                    r_store[r_cnt] <= w_next;
                    if (r_cnt == NR4) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rk_out = '0;
        if (r_ready && (rd_round <= NR4)) begin
            rk_out = r_store[NR4 - rd_round];
        end
    end

    assign busy  = r_busy;
    assign ready = r_ready;

endmodule

// File: tb/tb_dec_keyschedule.sv
module tb_dec_keyschedule;
    import dec_pkg::*;

    logic       clk;
    logic       rst;
    blk_t       key_in;
    logic       load;
    logic [3:0] rd_round;
    logic       busy;
    logic       ready;
    blk_t       rk_out;

    int n_vec;
    int n_err;

    dec_keyschedule dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .load     (load),
        .rd_round (rd_round),
        .busy     (busy),
        .ready    (ready),
        .rk_out   (rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encrypt round keys 0..10 for the FIPS-197 example key.
    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // Encrypt round keys 0..10 for the all-zero key.
    logic [127:0] zero_rk [0:10] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    function automatic blk_t hex2blk(input logic [127:0] h);
        blk_t b;
        for (int k = 0; k < 16; k++) begin
            b[k % 4][k / 4] = h[127 - 8*k -: 8];
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end
    endtask

    // Drive a load pulse that the next rising edge (E0) samples.
    task automatic pulse_load(input logic [127:0] k);
        @(negedge clk);
        key_in = hex2blk(k);
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // After a load edge, count busy cycles and locate the first ready edge.
    task automatic time_expansion(input string tag);
        int first_rdy;
        int nbusy;
        first_rdy = -1;
        nbusy     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (ready && first_rdy < 0) begin
                first_rdy = i;
                chk({tag, "_busy_at_ready"}, 128'(busy), 128'd0);
            end
        end
        chk({tag, "_ready_edge"}, 128'(first_rdy), 128'd10);
        chk({tag, "_busy_cycles"}, 128'(nbusy), 128'd10);
    endtask

    task automatic check_all(input string tag, input logic is_fips);
        for (int r = 0; r <= 10; r++) begin
            rd_round = 4'(r);
            #1;
            chk($sformatf("%s_rd%0d", tag, r), rk_out,
                is_fips ? hex2blk(fips_rk[10 - r]) : hex2blk(zero_rk[10 - r]));
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        load     = 1'b0;
        key_in   = '0;
        rd_round = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ready", 128'(ready), 128'd0);
        for (int r = 0; r < 16; r += 5) begin
            rd_round = 4'(r);
            #1;
            chk($sformatf("pre_rd%0d", r), rk_out, 128'd0);
        end

        pulse_load(fips_rk[0]);
        chk("fips_busy_e0", 128'(busy), 128'd1);
        chk("fips_ready_e0", 128'(ready), 128'd0);
        time_expansion("fips");
        check_all("fips", 1'b1);

        for (int r = 11; r < 16; r++) begin
            rd_round = 4'(r);
            #1;
            chk($sformatf("oob_rd%0d", r), rk_out, 128'd0);
        end

        repeat (20) @(posedge clk);
        @(negedge clk);
        rd_round = 4'd0;
        #1;
        chk("hold_ready", 128'(ready), 128'd1);
        chk("hold_busy", 128'(busy), 128'd0);
        chk("hold_rd0", rk_out, hex2blk(fips_rk[10]));

        pulse_load(fips_rk[0]);
        chk("reload_ready_drop", 128'(ready), 128'd0);
        repeat (3) @(posedge clk);
        pulse_load(zero_rk[0]);
        time_expansion("restart");
        check_all("restart", 1'b0);

        pulse_load(fips_rk[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_busy", 128'(busy), 128'd0);
        chk("async_ready", 128'(ready), 128'd0);
        chk("async_rk", rk_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle_ready", 128'(ready), 128'd0);
        chk("post_rst_idle_busy", 128'(busy), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
